// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : branch_predictor                                              |
// | Purpose  : Fetch-stage branch predictor. Direct-mapped BTB with a 2-bit  |
// |            saturating counter per entry and a run-time policy select.    |
// |            Also keeps resolved-branch and mispredict statistics.         |
// | Ports    : Clk, Reset            - clock, synchronous active-high reset  |
// |            mode                  - 0 not-taken, 1 always-taken on hit,   |
// |                                    2/3 2-bit counter                     |
// |            pc_in                 - IF lookup PC (combinational query)    |
// |            btb_hit, predict_*    - lookup results                        |
// |            update_*              - resolved branch/jump from EX          |
// |            mispredict            - combinational flush request           |
// |            num_branch,           - saturating statistics counters        |
// |            num_mispredict                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module branch_predictor #(
  parameter int           WORD_SIZE  = 16,
  parameter int           IDX_BITS   = 4,
  parameter logic [1:0]   CNT_INIT_T = 2'b10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           mode,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 btb_hit,
  output logic                 predict_taken,
  output logic [WORD_SIZE-1:0] predict_next_pc,
  input  logic                 update_valid,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic                 update_taken,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_pred_taken,
  input  logic [WORD_SIZE-1:0] update_pred_target,
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] num_branch,
  output logic [WORD_SIZE-1:0] num_mispredict
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - IDX_BITS;

  localparam logic [1:0]           C_CTR_MAX = 2'b11;
  localparam logic [1:0]           C_CTR_MIN = 2'b00;
  localparam logic [WORD_SIZE-1:0] C_ONE     = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WORD_SIZE-1:0] C_ALL1    = {WORD_SIZE{1'b1}};

  // Table state
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [1:0]           ctr_q    [ENTRIES];
  logic [1:0]           ctr_d    [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [WORD_SIZE-1:0] target_d [ENTRIES];

  logic [WORD_SIZE-1:0] num_branch_q, num_branch_d;
  logic [WORD_SIZE-1:0] num_mispredict_q, num_mispredict_d;

  // Lookup side
  logic [IDX_BITS-1:0]  lk_idx;
  logic [TAG_W-1:0]     lk_tag;

  // Update side
  logic [IDX_BITS-1:0]  up_idx;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit;

  assign lk_idx = pc_in[IDX_BITS-1:0];
  assign lk_tag = pc_in[WORD_SIZE-1:IDX_BITS];
  assign up_idx = update_pc[IDX_BITS-1:0];
  assign up_tag = update_pc[WORD_SIZE-1:IDX_BITS];

  // ---------------------------------------------------------------------------
  // Combinational lookup; always sees pre-update table contents (no bypass).
  // ---------------------------------------------------------------------------
  always_comb begin
    btb_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    case (mode)
      2'd0:    predict_taken = 1'b0;
      2'd1:    predict_taken = btb_hit;
      default: predict_taken = btb_hit && ctr_q[lk_idx][1];
    endcase
    predict_next_pc = predict_taken ? target_q[lk_idx] : (pc_in + C_ONE);
  end

  // ---------------------------------------------------------------------------
  // Mispredict: direction wrong, or taken with the wrong target.
  // ---------------------------------------------------------------------------
  always_comb begin
    mispredict = 1'b0;
    if (update_valid) begin
      mispredict = (update_pred_taken != update_taken) ||
                   (update_taken && (update_pred_target != update_target));
    end
  end

  // ---------------------------------------------------------------------------
  // Table next-state. Training happens in every mode so a mode switch never
  // needs a warm-up period.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          target_d[up_idx] = update_target;
          if (ctr_q[up_idx] != C_CTR_MAX) begin
            ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
          end
        end else if (ctr_q[up_idx] != C_CTR_MIN) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
        end
      end else if (update_taken) begin
        // Allocate on taken miss, evicting any aliasing occupant.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
        ctr_d[up_idx]    = CNT_INIT_T;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    num_branch_d     = num_branch_q;
    num_mispredict_d = num_mispredict_q;
    if (update_valid) begin
      if (num_branch_q != C_ALL1) begin
        num_branch_d = num_branch_q + C_ONE;
      end
      if (mispredict && (num_mispredict_q != C_ALL1)) begin
        num_mispredict_d = num_mispredict_q + C_ONE;
      end
    end
  end

  // Resettable state. A reset edge drops any concurrent update.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q          <= '0;
      num_branch_q     <= '0;
      num_mispredict_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else begin
      valid_q          <= valid_d;
      num_branch_q     <= num_branch_d;
      num_mispredict_q <= num_mispredict_d;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      tag_q[i]    <= tag_d[i];
      target_q[i] <= target_d[i];
    end
  end

  assign num_branch     = num_branch_q;
  assign num_mispredict = num_mispredict_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_branch_predictor                                           |
// | Purpose  : Self-checking bench for branch_predictor (default params).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] pc_in;
  logic        btb_hit;
  logic        predict_taken;
  logic [15:0] predict_next_pc;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_pred_taken;
  logic [15:0] update_pred_target;
  logic        mispredict;
  logic [15:0] num_branch;
  logic [15:0] num_mispredict;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 0;

  // Reference model: a table keyed by pc mod 16 holding (valid, pc div 16,
  // target, confidence 0..3), plus integer statistics.
  bit m_valid  [16];
  int m_tag    [16];
  int m_target [16];
  int m_ctr    [16];
  int m_nb = 0;
  int m_nm = 0;

  branch_predictor dut (
    .Clk                (clk),
    .Reset              (rst),
    .mode               (mode),
    .pc_in              (pc_in),
    .btb_hit            (btb_hit),
    .predict_taken      (predict_taken),
    .predict_next_pc    (predict_next_pc),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .mispredict         (mispredict),
    .num_branch         (num_branch),
    .num_mispredict     (num_mispredict)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit model_mispredict();
    if (!update_valid) return 0;
    return (update_pred_taken != update_taken) ||
           (update_taken && (update_pred_target != update_target));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance at the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 0;
      end
      m_nb = 0;
      m_nm = 0;
    end else if (update_valid) begin
      int idx;
      int tg;
      idx = int'(update_pc) % 16;
      tg  = int'(update_pc) / 16;
      if (model_mispredict()) m_nm = (m_nm < 65535) ? m_nm + 1 : 65535;
      m_nb = (m_nb < 65535) ? m_nb + 1 : 65535;
      if (m_valid[idx] && m_tag[idx] == tg) begin
        if (update_taken) begin
          m_target[idx] = int'(update_target);
          m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        end else begin
          m_ctr[idx]    = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (update_taken) begin
        m_valid[idx]  = 1;
        m_tag[idx]    = tg;
        m_target[idx] = int'(update_target);
        m_ctr[idx]    = 2;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int  idx;
      bit  e_hit;
      bit  e_taken;
      int  e_next;
      idx   = int'(pc_in) % 16;
      e_hit = m_valid[idx] && (m_tag[idx] == int'(pc_in) / 16);
      case (mode)
        2'd0:    e_taken = 0;
        2'd1:    e_taken = e_hit;
        default: e_taken = e_hit && (m_ctr[idx] >= 2);
      endcase
      e_next = e_taken ? m_target[idx] : (int'(pc_in) + 1) % 65536;
      check("cyc_btb_hit",        int'(btb_hit),         int'(e_hit));
      check("cyc_predict_taken",  int'(predict_taken),   int'(e_taken));
      check("cyc_next_pc",        int'(predict_next_pc), e_next);
      check("cyc_mispredict",     int'(mispredict),      int'(model_mispredict()));
      check("cyc_num_branch",     int'(num_branch),      m_nb);
      check("cyc_num_mispredict", int'(num_mispredict),  m_nm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                     input logic ptk, input logic [15:0] ptgt);
    update_valid       = 1;
    update_pc          = pc;
    update_taken       = tk;
    update_target      = tgt;
    update_pred_taken  = ptk;
    update_pred_target = ptgt;
  endtask

  initial begin
    rst = 1; mode = 2; pc_in = 16'h0010;
    update_valid = 0; update_pc = 0; update_taken = 0; update_target = 0;
    update_pred_taken = 0; update_pred_target = 0;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    #1;
    // Post-reset state
    check("rst_hit",   int'(btb_hit),         0);
    check("rst_taken", int'(predict_taken),   0);
    check("rst_next",  int'(predict_next_pc), 16'h0011);
    check("rst_nb",    int'(num_branch),      0);
    check("rst_nm",    int'(num_mispredict),  0);

    // First allocation, mispredicted as not-taken
    upd(16'h0010, 1, 16'h0040, 0, 16'h0011);
    #1 check("alloc_mispredict", int'(mispredict), 1);
    tick(); update_valid = 0;
    #1;
    check("alloc_hit",   int'(btb_hit),         1);
    check("alloc_taken", int'(predict_taken),   1);
    check("alloc_next",  int'(predict_next_pc), 16'h0040);
    check("alloc_nm",    int'(num_mispredict),  1);
    check("alloc_nb",    int'(num_branch),      1);

    // Two not-taken: counter 2 -> 0
    upd(16'h0010, 0, 16'h0000, 1, 16'h0040); tick(); tick();
    update_valid = 0; #1;
    check("ctr0_taken", int'(predict_taken),   0);
    check("ctr0_next",  int'(predict_next_pc), 16'h0011);
    // Four taken saturate at 3, one not-taken still predicts taken
    upd(16'h0010, 1, 16'h0040, 0, 16'h0011);
    repeat (4) tick();
    upd(16'h0010, 0, 16'h0000, 1, 16'h0040); tick();
    update_valid = 0; #1;
    check("sat_taken", int'(predict_taken), 1);

    // Same-cycle update and lookup: counter 2 -> 1, old prediction this cycle
    upd(16'h0010, 0, 16'h0000, 1, 16'h0040);
    #1 check("same_old_taken", int'(predict_taken), 1);
    tick(); update_valid = 0; #1;
    check("same_new_taken", int'(predict_taken), 0);

    // Aliasing eviction and no allocation on not-taken miss
    upd(16'h0110, 1, 16'h0200, 0, 16'h0111); tick();
    update_valid = 0; #1;
    check("alias_old_hit", int'(btb_hit), 0);
    pc_in = 16'h0110; #1;
    check("alias_new_hit",  int'(btb_hit),         1);
    check("alias_new_next", int'(predict_next_pc), 16'h0200);
    upd(16'h0055, 0, 16'h0000, 0, 16'h0056); tick();
    update_valid = 0; pc_in = 16'h0055; #1;
    check("nt_miss_hit", int'(btb_hit), 0);

    // Mode 1 / mode 0 on an entry whose counter is driven to 0
    upd(16'h0110, 0, 16'h0000, 0, 16'h0111); tick(); tick();
    update_valid = 0; pc_in = 16'h0110; mode = 1; #1;
    check("m1_taken", int'(predict_taken),   1);
    check("m1_next",  int'(predict_next_pc), 16'h0200);
    mode = 0; #1;
    check("m0_next",  int'(predict_next_pc), 16'h0111);
    mode = 2; pc_in = 16'hFFFF; #1;
    check("wrap_next", int'(predict_next_pc), 16'h0000);
    tick();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] tgt;
      mode  = 2'($urandom_range(0, 3));
      pc_in = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      rst   = ($urandom_range(0, 199) == 0);
      tgt   = 16'($urandom);
      if ($urandom_range(0, 1) == 1) tgt = 16'($urandom_range(0, 3));
      upd(16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15)),
          1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) == 1) ? tgt : 16'($urandom_range(0, 3)));
      update_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0;

    // Reset during an update drops the update and clears the table
    upd(16'h0110, 1, 16'h0200, 0, 16'h0111); tick(); tick();
    upd(16'h0020, 1, 16'h0300, 0, 16'h0021);
    rst = 1; tick();
    rst = 0; update_valid = 0; mode = 1; pc_in = 16'h0020; #1;
    check("rstupd_hit",  int'(btb_hit), 0);
    pc_in = 16'h0110; #1;
    check("rstclr_hit",  int'(btb_hit),    0);
    check("rstclr_nb",   int'(num_branch), 0);
    tick();

    // Drive both statistics counters to saturation and beyond
    upd(16'h0030, 0, 16'h0000, 1, 16'h0031);
    repeat (65540) tick();
    update_valid = 0; #1;
    check("sat_nb", int'(num_branch),     16'hFFFF);
    check("sat_nm", int'(num_mispredict), 16'hFFFF);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised fetch-stage branch predictor for the pipelined datapath: a direct-mapped branch target buffer (BTB) plus per-entry 2-bit saturating counters.
- Generalises the fixed always-taken policy into a run-time-selectable policy (not-taken / always-taken / 2-bit) with configurable table depth and word width.
- IF queries it combinationally each cycle; EX reports resolved branches and jumps through the update port.
- Also keeps branch and mispredict statistics counters.

Parameters:
- WORD_SIZE, 16, PC/target width in bits.
- IDX_BITS, 4, BTB index width; the table holds 2**IDX_BITS entries; must be 1..WORD_SIZE-1.
- CNT_INIT_T, 2'b10, counter value written when allocating an entry on a taken outcome.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- mode  in  2  policy: 0 = always-not-taken, 1 = always-taken (BTB hit), 2 = 2-bit counter, 3 = treated as 2.
- pc_in  in  WORD_SIZE  PC being fetched in IF.
- btb_hit  out  1  valid entry whose tag matches pc_in.
- predict_taken  out  1  predicted redirect.
- predict_next_pc  out  WORD_SIZE  next fetch PC.
- update_valid  in  1  a resolved control instruction in EX (not a bubble).
- update_pc  in  WORD_SIZE  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_target  in  WORD_SIZE  actual taken target.
- update_pred_taken  in  1  prediction made for it, carried down the pipeline.
- update_pred_target  in  WORD_SIZE  predicted next PC carried down the pipeline.
- mispredict  out  1  combinational flush request for the current update.
- num_branch  out  WORD_SIZE  resolved-update count.
- num_mispredict  out  WORD_SIZE  mispredict count.

Behaviour:
- Addressing: index = PC[IDX_BITS-1:0]; tag = PC[WORD_SIZE-1:IDX_BITS].
- Each entry holds: valid, tag, target (WORD_SIZE), ctr (2 bits).
- Lookup is purely combinational, zero latency:
  - btb_hit = valid[idx] && tag[idx] == pc_in tag.
  - mode 0: predict_taken = 0.
  - mode 1: predict_taken = btb_hit.
  - mode 2/3: predict_taken = btb_hit && ctr[idx][1].
  - predict_next_pc = predict_taken ? target[idx] : pc_in + 1, wrapping modulo 2**WORD_SIZE.
- mispredict (combinational, only when update_valid = 1):
  - asserted if update_pred_taken != update_taken;
  - or if update_taken && update_pred_target != update_target;
  - otherwise 0. Always 0 when update_valid = 0.
- Update takes effect on the rising edge when update_valid = 1, in every mode, so switching mode needs no retraining.
- Update, tag hit:
  - ctr saturating: taken increments, max 3; not taken decrements, min 0.
  - target overwritten only when taken.
- Update, miss or invalid entry:
  - taken: allocate, set valid = 1, write tag and target, ctr = CNT_INIT_T (replaces any previous occupant).
  - not taken: no allocation; table unchanged.
- Counters: num_branch += 1 per update; num_mispredict += 1 when mispredict. Both saturate at all-ones, no wrap.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. No bypass; new contents are visible the next cycle.
- Reset (Reset = 1 at the edge):
  - all valid = 0, all ctr = 0, num_branch = 0, num_mispredict = 0;
  - any concurrent update is discarded.
  - Post-reset outputs: btb_hit = 0, predict_taken = 0, predict_next_pc = pc_in + 1, mispredict follows its inputs.
- Targets and tags are not required to reset.
- Reset asserted mid-training discards all history; no partial state survives.
- No handshake or back-pressure: the pipeline's stall and flush logic gates update_valid and ignores outputs while stalled.

Test Plan:
- Reset, mode 2, pc_in = 16'h0010 -> btb_hit = 0, predict_taken = 0, predict_next_pc = 16'h0011, both counters 0.
- Mode 2: update pc 16'h0010 taken, target 16'h0040, pred_taken 0 -> mispredict = 1; next cycle lookup 16'h0010 gives hit, taken, next 16'h0040; num_mispredict = 1, num_branch = 1.
- Same entry: two not-taken updates -> ctr 2 → 1 → 0, prediction not-taken; four taken updates -> ctr saturates at 3; one not-taken -> still predicts taken.
- Aliasing (IDX_BITS = 4): entry at 16'h0010, then taken update at 16'h0110 target 16'h0200 -> 16'h0010 now misses, 16'h0110 hits; a not-taken update at a missing PC allocates nothing.
- Mode 1 vs mode 0 on the trained entry -> mode 1 predicts taken regardless of ctr = 0; mode 0 gives next = pc+1; pc_in = 16'hFFFF miss -> next = 16'h0000.
- Same-cycle update and lookup of 16'h0010 -> old prediction this cycle, new next cycle; Reset during updates -> table cleared and update dropped; counters held at 16'hFFFF do not wrap.
